// File: rtl/hazard_ctrl_if.sv
// Hazard-controller signal bundle: pipeline-stage observations in, stall/flush/forward
// controls and performance counters out.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       rs1_addrD;
  logic [4:0]       rs2_addrD;
  logic             uses_rs1D;
  logic             uses_rs2D;
  logic [4:0]       rs1_addrE;
  logic [4:0]       rs2_addrE;
  logic [4:0]       rdE;
  logic             MemReadE;
  logic             PCSrcE;
  logic [4:0]       rdM;
  logic             RegWriteM;
  logic             mem_reqM;
  logic             mem_readyM;
  logic [4:0]       rdW;
  logic             RegWriteW;

  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             bus_error;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs1_addrD, rs2_addrD, uses_rs1D, uses_rs2D, rs1_addrE, rs2_addrE, rdE,
           MemReadE, PCSrcE, rdM, RegWriteM, mem_reqM, mem_readyM, rdW, RegWriteW,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE,
           bus_error, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_addrD, rs2_addrD, uses_rs1D, uses_rs2D, rs1_addrE, rs2_addrE, rdE,
           MemReadE, PCSrcE, rdM, RegWriteM, mem_reqM, mem_readyM, rdW, RegWriteW,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE,
           bus_error, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stalls, redirect flushes, EX forwarding
// selects and a data-memory wait/timeout FSM with saturating performance counters.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input logic        clk,
  input logic        rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {StRun, StWait, StError} state_e;

  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic mem_busy, loaduse, run_eval;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;

  always_comb begin
    hz.ForwardAE = 2'b00;
    if (hz.RegWriteM && hz.rdM != 5'd0 && hz.rdM == hz.rs1_addrE) begin
      hz.ForwardAE = 2'b10;
    end else if (hz.RegWriteW && hz.rdW != 5'd0 && hz.rdW == hz.rs1_addrE) begin
      hz.ForwardAE = 2'b01;
    end
    hz.ForwardBE = 2'b00;
    if (hz.RegWriteM && hz.rdM != 5'd0 && hz.rdM == hz.rs2_addrE) begin
      hz.ForwardBE = 2'b10;
    end else if (hz.RegWriteW && hz.rdW != 5'd0 && hz.rdW == hz.rs2_addrE) begin
      hz.ForwardBE = 2'b01;
    end
  end

  assign mem_busy = hz.mem_reqM && !hz.mem_readyM;
  assign loaduse  = hz.MemReadE && hz.rdE != 5'd0 &&
                    ((hz.uses_rs1D && hz.rdE == hz.rs1_addrD) ||
                     (hz.uses_rs2D && hz.rdE == hz.rs2_addrD));

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    run_eval = 1'b0;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;

    case (state_q)
      StRun: begin
        if (mem_busy) begin
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          state_d = StWait;
          wait_d  = 8'd1;
        end else begin
          run_eval = 1'b1;
        end
      end
      StWait: begin
        if (hz.mem_readyM) begin
          run_eval = 1'b1;
          state_d  = StRun;
          wait_d   = 8'd0;
        end else begin
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          if (wait_q == WaitLast) begin
            state_d = StError;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
      end
      StError: begin
        {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
      end
      default: begin
        state_d = StRun;
        wait_d  = 8'd0;
      end
    endcase

    // Redirect outranks load-use: the stalled ID instruction is squashed anyway.
    if (run_eval) begin
      if (hz.PCSrcE) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (loaduse) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      wait_q      <= 8'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (stall_f && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flush_e && hz.PCSrcE && state_q != StError && flush_cnt_q != '1) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.StallM    = stall_m;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.bus_error = (state_q == StError);
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs change on the falling edge, outputs are checked
// 1 ns later, counters are checked one falling edge after the rising edge that updates them.
module tb_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  hazard_ctrl_if #(.CNT_W(4)) hz ();

  hazard_ctrl #(
    .MEM_TIMEOUT(4),
    .CNT_W      (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    hz.rs1_addrD  = 5'd0;
    hz.rs2_addrD  = 5'd0;
    hz.uses_rs1D  = 1'b0;
    hz.uses_rs2D  = 1'b0;
    hz.rs1_addrE  = 5'd0;
    hz.rs2_addrE  = 5'd0;
    hz.rdE        = 5'd0;
    hz.MemReadE   = 1'b0;
    hz.PCSrcE     = 1'b0;
    hz.rdM        = 5'd0;
    hz.RegWriteM  = 1'b0;
    hz.mem_reqM   = 1'b0;
    hz.mem_readyM = 1'b0;
    hz.rdW        = 5'd0;
    hz.RegWriteW  = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Stall/flush vector packed as {StallF, StallD, StallE, StallM, FlushD, FlushE}.
  function automatic logic [31:0] ctl();
    return 32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE});
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    apply_reset();

    // Reset state
    #1;
    check("rst_stall_cnt", 32'(hz.stall_cnt), 0);
    check("rst_flush_cnt", 32'(hz.flush_cnt), 0);
    check("rst_bus_error", 32'(hz.bus_error), 0);
    check("rst_ctl", ctl(), 32'b000000);

    // Forwarding
    hz.rdM = 5'd5; hz.RegWriteM = 1'b1; hz.rdW = 5'd5; hz.RegWriteW = 1'b1;
    hz.rs1_addrE = 5'd5; hz.rs2_addrE = 5'd7;
    #1;
    check("fwdA_mem", 32'(hz.ForwardAE), 2);
    check("fwdB_none", 32'(hz.ForwardBE), 0);
    hz.rs2_addrE = 5'd5;
    #1;
    check("fwdB_mem", 32'(hz.ForwardBE), 2);
    hz.RegWriteM = 1'b0;
    #1;
    check("fwdA_wb", 32'(hz.ForwardAE), 1);
    hz.RegWriteM = 1'b1; hz.rdM = 5'd0; hz.rdW = 5'd0; hz.rs1_addrE = 5'd0;
    #1;
    check("fwdA_x0", 32'(hz.ForwardAE), 0);
    check("fwdB_x0", 32'(hz.ForwardBE), 0);
    check("fwd_no_ctl", ctl(), 32'b000000);

    // Load-use
    @(negedge clk);
    idle();
    hz.MemReadE = 1'b1; hz.rdE = 5'd3; hz.rs2_addrD = 5'd3; hz.uses_rs2D = 1'b1;
    #1;
    check("lu_ctl", ctl(), 32'b110001);
    @(negedge clk);
    check("lu_stall_cnt", 32'(hz.stall_cnt), 1);
    hz.MemReadE = 1'b0;
    #1;
    check("lu_one_cycle", ctl(), 32'b000000);
    hz.MemReadE = 1'b1; hz.uses_rs2D = 1'b0;
    #1;
    check("lu_unused_rs2", ctl(), 32'b000000);
    hz.uses_rs1D = 1'b1; hz.rs1_addrD = 5'd0; hz.rdE = 5'd0;
    #1;
    check("lu_rd_x0", ctl(), 32'b000000);
    @(negedge clk);
    check("lu_stall_cnt_hold", 32'(hz.stall_cnt), 1);

    // Branch beats load-use
    idle();
    hz.MemReadE = 1'b1; hz.rdE = 5'd3; hz.rs1_addrD = 5'd3; hz.uses_rs1D = 1'b1;
    hz.PCSrcE = 1'b1;
    #1;
    check("br_ctl", ctl(), 32'b000011);
    @(negedge clk);
    check("br_flush_cnt", 32'(hz.flush_cnt), 1);
    check("br_stall_cnt", 32'(hz.stall_cnt), 1);

    // Memory wait: 3 stalled cycles, ready in the 4th, PCSrcE held throughout
    apply_reset();
    hz.mem_reqM = 1'b1; hz.PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("mw_stall_%0d", i), ctl(), 32'b111100);
      @(negedge clk);
    end
    check("mw_stall_cnt", 32'(hz.stall_cnt), 3);
    check("mw_flush_cnt0", 32'(hz.flush_cnt), 0);
    hz.mem_readyM = 1'b1;
    #1;
    check("mw_ready_ctl", ctl(), 32'b000011);
    @(negedge clk);
    check("mw_flush_cnt1", 32'(hz.flush_cnt), 1);
    hz.PCSrcE = 1'b0;
    #1;
    check("mw_back_run", ctl(), 32'b000000);
    @(negedge clk);
    check("mw_stall_cnt_hold", 32'(hz.stall_cnt), 3);

    // Timeout with MEM_TIMEOUT=4
    apply_reset();
    hz.mem_reqM = 1'b1; hz.PCSrcE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("to_busy_%0d", i), 32'(hz.bus_error), 0);
      @(negedge clk);
    end
    check("to_bus_error", 32'(hz.bus_error), 1);
    check("to_stall_cnt", 32'(hz.stall_cnt), 4);
    hz.mem_readyM = 1'b1;
    #1;
    check("to_err_ctl", ctl(), 32'b111100);
    @(negedge clk);
    check("to_err_sticky", 32'(hz.bus_error), 1);
    check("to_err_flush_cnt", 32'(hz.flush_cnt), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("to_async_bus_error", 32'(hz.bus_error), 0);
    check("to_async_stall_cnt", 32'(hz.stall_cnt), 0);
    check("to_async_run_ctl", ctl(), 32'b000011);
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation with CNT_W=4: bus stays busy, so stalls continue through ERROR
    apply_reset();
    hz.mem_reqM = 1'b1;
    for (int i = 0; i < 14; i++) @(negedge clk);
    check("sat_14", 32'(hz.stall_cnt), 14);
    @(negedge clk);
    check("sat_15", 32'(hz.stall_cnt), 15);
    for (int i = 0; i < 5; i++) @(negedge clk);
    check("sat_hold", 32'(hz.stall_cnt), 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
